// File: rtl/cc_operand_packer_pkg.sv
// Shared types for the operand packer, compute core wrapper and bench scoreboard.
package cc_operand_packer_pkg;

    localparam int DATA_W = 4;
    localparam int OPT_W  = 3;
    localparam int NUM    = 4;
    localparam int CNT_W  = 2;

    // n[0] is the first beat of the frame
    typedef struct packed {
        logic [NUM-1:0][DATA_W-1:0] n;
        logic [OPT_W-1:0]           opt;
    } frame_t;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } state_t;

    // Drop one beat into its assembly slot; the opcode only rides on beat 0.
    function automatic frame_t put_beat(input frame_t f, input logic [CNT_W-1:0] idx,
                                        input logic [DATA_W-1:0] d, input logic [OPT_W-1:0] o);
        frame_t r;
        r        = f;
        r.n[idx] = d;
        if (idx == '0) begin
            r.opt = o;
        end
        return r;
    endfunction

endpackage

// File: rtl/cc_frame_slot.sv
// Registered frame holder with valid/ready handshake, load, drain and flush.
module cc_frame_slot
    import cc_operand_packer_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_clr,
    input  logic   i_load,
    input  frame_t i_frame,
    input  logic   i_ready,
    output logic   o_valid,
    output frame_t o_frame
);

    logic   r_valid;
    frame_t r_frame;

    // Valid flag: flush wins, a load refills (even while draining), a handshake empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Payload only changes on a load, so it holds through a flush and while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame <= '0;
        end else if (i_load && !i_clr) begin
            r_frame <= i_frame;
        end
    end

    assign o_valid = r_valid;
    assign o_frame = r_frame;

endmodule

// File: rtl/cc_operand_packer.sv
// Packs four serial operand beats plus the beat-0 opcode into one parallel frame.
// Assembly side is a two-state FSM; the output side is a cc_frame_slot.
module cc_operand_packer
    import cc_operand_packer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OPT_W-1:0]  in_opt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_n0,
    output logic [DATA_W-1:0] out_n1,
    output logic [DATA_W-1:0] out_n2,
    output logic [DATA_W-1:0] out_n3,
    output logic [OPT_W-1:0]  out_opt
);

    // ST_COLLECT : accepting beats, r_cnt is the next assembly slot
    // ST_FULL    : complete frame parked in r_asm, waiting for the output slot

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_run;
    logic [CNT_W-1:0] r_cnt;
    frame_t           r_asm;
    frame_t           w_asm_beat;
    frame_t           w_load_frame;
    frame_t           w_out_frame;
    logic             w_beat;
    logic             w_last;
    logic             w_slot_free;
    logic             w_load;
    logic             w_out_valid;

    assign w_beat      = in_valid && in_ready && !clr;
    assign w_last      = w_beat && (r_cnt == CNT_W'(NUM - 1));
    assign w_slot_free = !w_out_valid || out_ready;
    assign w_asm_beat  = put_beat(r_asm, r_cnt, in_data, in_opt);

    // in_ready must stay low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: park a finished frame only when the output slot can't take it this edge.
    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ST_COLLECT;
        end else begin
            case (r_state)
                ST_COLLECT: if (w_last && !w_slot_free) w_state_nxt = ST_FULL;
                ST_FULL:    if (out_ready)             w_state_nxt = ST_COLLECT;
                default:                               w_state_nxt = ST_COLLECT;
            endcase
        end
    end

    // FSM outputs: acceptance and what (if anything) moves into the output slot.
    always_comb begin
        in_ready     = r_run && (r_state == ST_COLLECT);
        w_load       = 1'b0;
        w_load_frame = w_asm_beat;
        if (!clr) begin
            if (r_state == ST_FULL) begin
                w_load       = out_ready;
                w_load_frame = r_asm;
            end else begin
                w_load = w_last && w_slot_free;
            end
        end
    end

    // Beat counter and assembly buffer; the counter wraps so a parked frame leaves it at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_asm <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (w_beat) begin
            r_cnt <= r_cnt + 1'b1;
            r_asm <= w_asm_beat;
        end
    end

    cc_frame_slot u_out_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (clr),
        .i_load  (w_load),
        .i_frame (w_load_frame),
        .i_ready (out_ready),
        .o_valid (w_out_valid),
        .o_frame (w_out_frame)
    );

    assign out_valid = w_out_valid;
    assign out_n0    = w_out_frame.n[0];
    assign out_n1    = w_out_frame.n[1];
    assign out_n2    = w_out_frame.n[2];
    assign out_n3    = w_out_frame.n[3];
    assign out_opt   = w_out_frame.opt;

endmodule

// File: tb/tb_cc_operand_packer.sv
// Directed + random bench for cc_operand_packer with a frame scoreboard.
module tb_cc_operand_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [2:0] in_opt;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_n0, out_n1, out_n2, out_n3;
    logic [2:0] out_opt;

    int checks = 0;
    int errors = 0;
    int rcv_cnt = 0;
    int exp_total = 0;
    bit rnd_en = 1'b0;
    logic [18:0] exp_q[$];

    cc_operand_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_opt    (in_opt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_n0    (out_n0),
        .out_n1    (out_n1),
        .out_n2    (out_n2),
        .out_n3    (out_n3),
        .out_opt   (out_opt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] mk(input logic [3:0] d0, input logic [3:0] d1,
                                       input logic [3:0] d2, input logic [3:0] d3,
                                       input logic [2:0] o);
        return {d0, d1, d2, d3, o};
    endfunction

    // Scoreboard: every completed output handshake must match the oldest expected frame.
    always @(posedge clk) begin
        if (rst_n && !clr && out_valid && out_ready) begin
            rcv_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", 32'(mk(out_n0, out_n1, out_n2, out_n3, out_opt)), 32'h7ffff);
            end else begin
                chk("frame", 32'(mk(out_n0, out_n1, out_n2, out_n3, out_opt)), 32'(exp_q.pop_front()));
            end
        end
    end

    // Inputs change on the falling edge; in_ready depends only on registers so it is settled here.
    task automatic send_beat(input logic [3:0] d, input logic [2:0] o);
        int n;
        n = 0;
        @(negedge clk);
        if (rnd_en) out_ready = 1'($urandom_range(0, 1));
        while (!in_ready || (rnd_en && $urandom_range(0, 3) == 0)) begin
            in_valid = 1'b0;
            n++;
            if (n > 1000) begin
                chk("beat_timeout", 32'(n), 32'd0);
                return;
            end
            @(negedge clk);
            if (rnd_en) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b1;
        in_data  = d;
        in_opt   = o;
    endtask

    task automatic send_frame(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                              input logic [3:0] d3, input logic [2:0] o, input bit push);
        logic [2:0] other;
        other = rnd_en ? 3'($urandom_range(0, 7)) : 3'd7;
        if (push) begin
            exp_q.push_back(mk(d0, d1, d2, d3, o));
            exp_total++;
        end
        send_beat(d0, o);
        send_beat(d1, other);
        send_beat(d2, other);
        send_beat(d3, other);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    logic [3:0] gv[4];

    initial begin
        int n;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_opt = '0; out_ready = 1'b1;
        gv = '{4'd3, 4'd6, 4'd9, 4'd12};

        // reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_n0", 32'(out_n0), 32'd0);
        chk("rst_out_opt", 32'(out_opt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // basic frame, out_ready high
        send_frame(4'd9, 4'd2, 4'd15, 4'd4, 3'd3, 1'b1);
        idle();
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_n0", 32'(out_n0), 32'd9);
        chk("basic_n1", 32'(out_n1), 32'd2);
        chk("basic_n2", 32'(out_n2), 32'd15);
        chk("basic_n3", 32'(out_n3), 32'd4);
        chk("basic_opt", 32'(out_opt), 32'd3);

        // reset mid-run with a held frame and a partial frame
        @(negedge clk);
        out_ready = 1'b0;
        send_frame(4'd5, 4'd6, 4'd7, 4'd8, 3'd1, 1'b0);
        send_beat(4'd1, 3'd7);
        send_beat(4'd1, 3'd7);
        idle();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_n0", 32'(out_n0), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrel_in_ready", 32'(in_ready), 32'd1);
        send_frame(4'd1, 4'd2, 4'd3, 4'd4, 3'd5, 1'b1);
        idle();
        chk("postrst_n0", 32'(out_n0), 32'd1);
        chk("postrst_n3", 32'(out_n3), 32'd4);

        // backpressure: two frames stack up
        @(negedge clk);
        out_ready = 1'b0;
        send_frame(4'd10, 4'd11, 4'd12, 4'd13, 3'd1, 1'b1);
        send_frame(4'd14, 4'd15, 4'd0, 4'd1, 3'd2, 1'b1);
        idle();
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_n0", 32'(out_n0), 32'd10);
        repeat (3) @(negedge clk);
        chk("bp_hold_n1", 32'(out_n1), 32'd11);
        chk("bp_hold_n3", 32'(out_n3), 32'd13);
        chk("bp_hold_opt", 32'(out_opt), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_n0", 32'(out_n0), 32'd14);
        chk("b2b_opt", 32'(out_opt), 32'd2);
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("b2b_drained", 32'(out_valid), 32'd0);

        // gaps: in_valid 1010...
        out_ready = 1'b0;
        exp_q.push_back(mk(4'd3, 4'd6, 4'd9, 4'd12, 3'd2));
        exp_total++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            in_data  = (i % 2 == 0) ? gv[i / 2] : 4'd15;
            in_opt   = (i == 0) ? 3'd2 : 3'd7;
        end
        idle();
        chk("gap_valid", 32'(out_valid), 32'd1);
        chk("gap_frame", 32'(mk(out_n0, out_n1, out_n2, out_n3, out_opt)),
            32'(mk(4'd3, 4'd6, 4'd9, 4'd12, 3'd2)));
        out_ready = 1'b1;
        @(negedge clk);
        chk("gap_drained", 32'(out_valid), 32'd0);

        // clr with a held frame and a partial frame; beat presented with clr is dropped
        out_ready = 1'b0;
        send_frame(4'd2, 4'd4, 4'd6, 4'd8, 3'd6, 1'b0);
        send_beat(4'd9, 3'd1);
        send_beat(4'd9, 3'd1);
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'd15; in_opt = 3'd0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_valid", 32'(out_valid), 32'd0);
        chk("clr_hold_n0", 32'(out_n0), 32'd2);
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        send_frame(4'd5, 4'd4, 4'd3, 4'd2, 3'd4, 1'b1);
        idle();
        chk("clr_new_frame", 32'(mk(out_n0, out_n1, out_n2, out_n3, out_opt)),
            32'(mk(4'd5, 4'd4, 4'd3, 4'd2, 3'd4)));

        // random frames with random out_ready
        rnd_en = 1'b1;
        repeat (64) begin
            send_frame(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       3'($urandom_range(0, 7)), 1'b1);
        end
        rnd_en = 1'b0;
        idle();
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("frame_count", 32'(rcv_cnt), 32'(exp_total));
        @(negedge clk);
        chk("final_valid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
